// File: rtl/spw_tx_packet_arbiter.sv
// spw_tx_packet_arbiter
// Packet-atomic round-robin arbiter in front of the SpwTCR TX FIFO write port.
// The grant is held from the first character up to the end marker. If the link
// leaves Run, the packet is closed with EEP and the rest of it is discarded.
// Optional feature macro: SPW_ARB_TIMEOUT_EN. It adds a mid-packet stall
// watchdog that aborts the packet after TIMEOUT_CYCLES idle owner cycles.
//
// state     | meaning
// IDLE      | no owner; arbitrate among valid sources while the link is in Run
// FORWARD   | owner characters pass to the codec FIFO
// TERMINATE | write EEP to close an aborted, already-started packet
// DISCARD   | drain and drop the owner's characters up to its end marker
module spw_tx_packet_arbiter #(
  parameter int         NUM_SRC        = 4,
  parameter logic [2:0] RUN_STATE      = 3'd5,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic [9*NUM_SRC-1:0]   SRC_DATA,
  input  logic [NUM_SRC-1:0]     SRC_VALID,
  output logic [NUM_SRC-1:0]     SRC_READY,
  input  logic [2:0]             CURRENTSTATE,
  input  logic                   TX_FULL,
  output logic [8:0]             DATA_I,
  output logic                   WR_DATA,
  output logic [NUM_SRC-1:0]     GRANT,
  output logic                   BUSY,
  output logic                   ABORT
);

  localparam int LW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, FORWARD, TERMINATE, DISCARD} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] grant;
  logic [LW-1:0]      last;
  logic [LW-1:0]      win;
  logic               found;
  logic               started;
  logic [8:0]         src_chr [NUM_SRC];
  logic               run;
  logic               own_valid;
  logic [8:0]         own_chr;
  logic               own_end;
  logic               fwd_rdy;
  logic               fwd_xfer;
  logic               timeout;
  int                 widx;
  logic [LW-1:0]      widx_l;

  // Unpack the flat source bus into one character per source
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) src_chr[i] = SRC_DATA[9*i +: 9];
  end

  // The owner index is the last winner for as long as the grant is held
  assign run       = (CURRENTSTATE == RUN_STATE);
  assign own_valid = SRC_VALID[last];
  assign own_chr   = src_chr[last];
  assign own_end   = own_chr[8] & (own_chr[7:1] == 7'd0);
  assign fwd_rdy   = run & ~TX_FULL & ~timeout;
  assign fwd_xfer  = own_valid & fwd_rdy;
  assign GRANT     = grant;
  assign BUSY      = (state != IDLE);

  // Round-robin search: first valid source starting after the last winner
  always_comb begin
    found  = 1'b0;
    win    = last;
    widx   = 0;
    widx_l = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      widx   = (int'(last) + k) % NUM_SRC;
      widx_l = LW'(widx);
      if (!found && SRC_VALID[widx_l]) begin
        found = 1'b1;
        win   = widx_l;
      end
    end
  end

  // State register
  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (run && found) state_nxt = FORWARD;
      FORWARD: begin
        if (!run || timeout)       state_nxt = started ? TERMINATE : DISCARD;
        else if (fwd_xfer && own_end) state_nxt = IDLE;
      end
      TERMINATE: if (!TX_FULL) state_nxt = DISCARD;
      DISCARD:   if (own_valid && own_end) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode; DATA_I stays zero on every cycle without a write
  always_comb begin
    SRC_READY = '0;
    WR_DATA   = 1'b0;
    DATA_I    = 9'h000;
    ABORT     = 1'b0;
    case (state)
      FORWARD: begin
        SRC_READY[last] = fwd_rdy;
        ABORT           = ~run | timeout;
        if (fwd_xfer) begin
          WR_DATA = 1'b1;
          DATA_I  = own_chr;
        end
      end
      TERMINATE: begin
        if (!TX_FULL) begin
          WR_DATA = 1'b1;
          DATA_I  = 9'h101;
        end
      end
      DISCARD: SRC_READY[last] = 1'b1;
      default: ;
    endcase
  end

  // Grant, round-robin pointer and packet-started flag
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      grant   <= '0;
      last    <= LW'(NUM_SRC - 1);
      started <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == FORWARD) begin
        grant   <= NUM_SRC'(1) << win;
        last    <= win;
        started <= 1'b0;
      end else if (state_nxt == IDLE) begin
        grant <= '0;
      end
      if (state == FORWARD && fwd_xfer) started <= 1'b1;
    end
  end

`ifdef SPW_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  // Count owner-starved cycles once the packet has begun; TX_FULL stalls do not count
  always_ff @(posedge CLOCK) begin
    if (RESET)                                                  wd_cnt <= '0;
    else if (state != FORWARD || state_nxt != FORWARD || fwd_xfer) wd_cnt <= '0;
    else if (started && !own_valid)                             wd_cnt <= wd_cnt + CW'(1);
  end

  assign timeout = (wd_cnt == CW'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spw_tx_packet_arbiter.sv
// Testbench for spw_tx_packet_arbiter: source models feed per-source buffers.
// Expected FIFO writes go into a scoreboard queue as each packet is loaded.
// Every observed write pops that queue and is compared against it.
module tb_spw_tx_packet_arbiter;
  localparam int NUM = 4;
  localparam int TO  = 1024;

  logic           clk = 1'b0;
  logic           rst;
  logic [9*NUM-1:0] src_data;
  logic [NUM-1:0] src_valid;
  logic [NUM-1:0] src_ready;
  logic [2:0]     cur_state;
  logic           tx_full;
  logic [8:0]     data_i;
  logic           wr_data;
  logic [NUM-1:0] grant;
  logic           busy;
  logic           abort;

  spw_tx_packet_arbiter #(.NUM_SRC(NUM), .RUN_STATE(3'd5), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK(clk), .RESET(rst), .SRC_DATA(src_data), .SRC_VALID(src_valid),
    .SRC_READY(src_ready), .CURRENTSTATE(cur_state), .TX_FULL(tx_full),
    .DATA_I(data_i), .WR_DATA(wr_data), .GRANT(grant), .BUSY(busy), .ABORT(abort)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_abort  = 0;
  int n_eep    = 0;

  logic [8:0] src_mem [NUM][64];
  int         src_rd [NUM];
  int         src_wr [NUM];
  logic [NUM-1:0] stall;
  logic [8:0] exp_q[$];
  logic [NUM-1:0] grant_log[$];
  logic [NUM-1:0] prev_grant;

  logic           s_wr, s_busy, s_abort;
  logic [8:0]     s_data;
  logic [NUM-1:0] s_ready, s_grant;

  task automatic clear_sources();
    for (int i = 0; i < NUM; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    stall = '0;
    exp_q.delete();
    grant_log.delete();
  endtask

  task automatic load(input int s, input logic [8:0] c);
    src_mem[s][src_wr[s]] = c;
    src_wr[s]++;
  endtask

  function automatic logic drained();
    for (int i = 0; i < NUM; i++) if (src_rd[i] != src_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive sources, sample at negedge, score writes, account handshakes
  task automatic tick();
    logic [8:0] e;
    for (int i = 0; i < NUM; i++) begin
      src_valid[i] = (src_rd[i] < src_wr[i]) && !stall[i];
      src_data[9*i +: 9] = src_valid[i] ? src_mem[i][src_rd[i]] : 9'h0;
    end
    @(negedge clk);
    s_wr = wr_data; s_data = data_i; s_ready = src_ready;
    s_grant = grant; s_busy = busy; s_abort = abort;
    if (s_abort === 1'b1) n_abort++;
    if (s_grant !== prev_grant) begin
      grant_log.push_back(s_grant);
      prev_grant = s_grant;
    end
    n_checks++;
    if (s_wr === 1'b1) begin
      n_wr++;
      if (s_data == 9'h101) n_eep++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got %h, none expected", s_data);
      end else begin
        e = exp_q.pop_front();
        if (s_data !== e) begin
          n_fail++;
          $display("FAIL write_data: got %h required %h", s_data, e);
        end
      end
    end else if (s_wr !== 1'b0 || s_data !== 9'h0) begin
      n_fail++;
      $display("FAIL idle_data: wr %b data %h required wr 0 data 000", s_wr, s_data);
    end
    n_checks++;
    if ((s_ready & ~s_grant) !== '0) begin
      n_fail++;
      $display("FAIL ready_non_owner: ready %b grant %b", s_ready, s_grant);
    end
    for (int i = 0; i < NUM; i++) if (src_valid[i] && s_ready[i]) src_rd[i]++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input string name, input int max);
    int g = 0;
    do begin
      tick();
      g++;
    end while (!(drained() && s_busy === 1'b0) && g < max);
    n_checks++;
    if (g >= max) begin
      n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, max);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_writes(input string name, input int target);
    int g = 0;
    while (n_wr < target && g < 50) begin
      tick();
      g++;
    end
    n_checks++;
    if (n_wr < target) begin
      n_fail++;
      $display("FAIL %s_wait: writes %0d required %0d", name, n_wr, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_grant = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_full = 1'b0; cur_state = 3'd5; src_valid = '0; src_data = '0;
    clear_sources();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (grant !== '0 || wr_data !== 1'b0 || data_i !== 9'h0 || busy !== 1'b0 ||
        abort !== 1'b0 || src_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant %b wr %b data %h busy %b abort %b ready %b, required all 0",
               grant, wr_data, data_i, busy, abort, src_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    prev_grant = '0;
  endtask

  task automatic test_two_sources();
    logic [NUM-1:0] exp_g [4];
    clear_sources();
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0000; exp_g[2] = 4'b0100; exp_g[3] = 4'b0000;
    for (int k = 0; k < 3; k++) load(0, 9'(8'hA0 + k));
    load(0, 9'h100);
    for (int k = 0; k < 3; k++) load(2, 9'(8'hC0 + k));
    load(2, 9'h100);
    for (int k = 0; k < 3; k++) exp_q.push_back(9'(8'hA0 + k));
    exp_q.push_back(9'h100);
    for (int k = 0; k < 3; k++) exp_q.push_back(9'(8'hC0 + k));
    exp_q.push_back(9'h100);
    run_until_idle("two_src", 40);
    n_checks++;
    if (grant_log.size() != 4) begin
      n_fail++;
      $display("FAIL two_src_grant_count: %0d changes required 4", grant_log.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (grant_log[j] !== exp_g[j]) begin
          n_fail++;
          $display("FAIL two_src_grant_seq[%0d]: got %b required %b", j, grant_log[j], exp_g[j]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int j = 0;
    int bad = 0;
    int cnt [NUM];
    do_reset();
    clear_sources();
    for (int i = 0; i < NUM; i++) cnt[i] = 0;
    for (int p = 0; p < 10; p++)
      for (int s = 0; s < NUM; s++) begin
        load(s, 9'(s * 16 + p));
        load(s, 9'h100);
        exp_q.push_back(9'(s * 16 + p));
        exp_q.push_back(9'h100);
      end
    run_until_idle("fair", 400);
    foreach (grant_log[k]) begin
      if (grant_log[k] != '0) begin
        if (grant_log[k] !== 4'(1 << (j % NUM))) bad++;
        for (int i = 0; i < NUM; i++) if (grant_log[k][i]) cnt[i]++;
        j++;
      end
    end
    n_checks++;
    if (bad != 0 || j != 40) begin
      n_fail++;
      $display("FAIL fair_order: %0d grants, %0d out of order, required 40 and 0", j, bad);
    end
    for (int i = 0; i < NUM; i++) begin
      n_checks++;
      if (cnt[i] != 10) begin
        n_fail++;
        $display("FAIL fair_share[%0d]: got %0d packets required 10", i, cnt[i]);
      end
    end
  endtask

  task automatic test_tx_full();
    int base;
    clear_sources();
    for (int k = 0; k < 8; k++) begin
      load(1, 9'(8'h10 + k));
      exp_q.push_back(9'(8'h10 + k));
    end
    load(1, 9'h100);
    exp_q.push_back(9'h100);
    base = n_wr;
    wait_writes("full", base + 3);
    tx_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (s_wr !== 1'b0 || s_ready !== '0) begin
        n_fail++;
        $display("FAIL full_hold[%0d]: wr %b ready %b required 0 and 0000", c, s_wr, s_ready);
      end
    end
    tx_full = 1'b0;
    tick();
    n_checks++;
    if (s_wr !== 1'b1 || s_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL full_resume: wr %b ready %b required 1 and 0010", s_wr, s_ready);
    end
    run_until_idle("full", 40);
  endtask

  task automatic test_link_drop();
    int base, ab0, eep0;
    clear_sources();
    for (int k = 0; k < 6; k++) load(3, 9'(8'h30 + k));
    load(3, 9'h100);
    exp_q.push_back(9'h030);
    exp_q.push_back(9'h031);
    exp_q.push_back(9'h101);
    base = n_wr;
    wait_writes("drop", base + 2);
    ab0 = n_abort; eep0 = n_eep;
    cur_state = 3'd0;
    tick();
    n_checks++;
    if (s_abort !== 1'b1 || s_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_abort: abort %b wr %b required 1 and 0", s_abort, s_wr);
    end
    run_until_idle("drop", 40);
    n_checks++;
    if (n_eep - eep0 != 1 || n_wr - base != 3) begin
      n_fail++;
      $display("FAIL drop_eep: eep writes %0d total %0d required 1 and 3", n_eep - eep0, n_wr - base);
    end
    n_checks++;
    if (n_abort - ab0 != 1) begin
      n_fail++;
      $display("FAIL drop_abort_count: got %0d required 1", n_abort - ab0);
    end
    n_checks++;
    if (s_busy !== 1'b0 || s_grant !== '0) begin
      n_fail++;
      $display("FAIL drop_release: busy %b grant %b required 0 and 0000", s_busy, s_grant);
    end
    cur_state = 3'd5;
  endtask

  task automatic test_stall();
    int base, ab0;
    int exp_ab, exp_wr;
    clear_sources();
    load(0, 9'h0D0); load(0, 9'h0D1); load(0, 9'h100);
    exp_q.push_back(9'h0D0);
`ifdef SPW_ARB_TIMEOUT_EN
    exp_q.push_back(9'h101);
    exp_ab = 1; exp_wr = 2;
`else
    exp_q.push_back(9'h0D1);
    exp_q.push_back(9'h100);
    exp_ab = 0; exp_wr = 1;
`endif
    base = n_wr;
    wait_writes("stall", base + 1);
    ab0 = n_abort;
    stall[0] = 1'b1;
    repeat (TO + 8) tick();
    n_checks++;
    if (n_abort - ab0 != exp_ab) begin
      n_fail++;
      $display("FAIL stall_abort: got %0d pulses required %0d", n_abort - ab0, exp_ab);
    end
    n_checks++;
    if (n_wr - base != exp_wr) begin
      n_fail++;
      $display("FAIL stall_writes: got %0d required %0d", n_wr - base, exp_wr);
    end
    n_checks++;
    if (s_grant !== 4'b0001 || s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_grant_held: grant %b busy %b required 0001 and 1", s_grant, s_busy);
    end
    stall[0] = 1'b0;
    run_until_idle("stall", 40);
  endtask

  task automatic test_reset_mid_packet();
    int base;
    logic [NUM-1:0] first;
    clear_sources();
    for (int k = 0; k < 6; k++) begin
      load(2, 9'(8'h50 + k));
      exp_q.push_back(9'(8'h50 + k));
    end
    load(2, 9'h100);
    base = n_wr;
    wait_writes("rst_mid", base + 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_sources();
    prev_grant = '0;
    tick();
    n_checks++;
    if (s_grant !== '0 || s_wr !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: grant %b wr %b busy %b required 0000 0 0", s_grant, s_wr, s_busy);
    end
    load(0, 9'h0E0); load(0, 9'h100);
    load(2, 9'h100);
    exp_q.push_back(9'h0E0); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
    run_until_idle("rst_mid", 40);
    first = (grant_log.size() > 0) ? grant_log[0] : '0;
    n_checks++;
    if (first !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_mid_first_grant: got %b required 0001", first);
    end
  endtask

  initial begin
    test_reset();
    test_two_sources();
    test_fairness();
    test_tx_full();
    test_link_drop();
    test_stall();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spw_tx_packet_arbiter.md
# spw_tx_packet_arbiter

Packet-atomic round-robin arbiter that shares the SpwTCR transmit FIFO write port (DATA_I / WR_DATA / TX_FULL) between NUM_SRC independent packet sources. A grant is held from the first character to the end-of-packet marker, so packets from different sources never interleave. Writes are gated on the codec link state. When the link leaves Run, or (optionally) when a source stalls mid-packet, the block closes the packet with EEP and discards the rest of that source's packet.

## Interface
- NUM_SRC, 4, number of requesting sources (2..8)
- RUN_STATE, 3'd5, CURRENTSTATE encoding for Run
- TIMEOUT_CYCLES, 1024, mid-packet source-stall limit in cycles (used only with the watchdog macro)
- CLOCK  in  1  system clock; same clock as the codec
- RESET  in  1  synchronous reset, active-high
- SRC_DATA  in  9*NUM_SRC  source i on bits [9i+8:9i]
  - bit 8 = control flag; EOP = 9'h100, EEP = 9'h101
- SRC_VALID  in  NUM_SRC  source i has a character
- SRC_READY  out  NUM_SRC  source i character consumed this cycle when VALID & READY
- CURRENTSTATE  in  3  codec link FSM state
- TX_FULL  in  1  codec TX FIFO full
- DATA_I  out  9  character to codec TX FIFO
- WR_DATA  out  1  write strobe to codec TX FIFO
- GRANT  out  NUM_SRC  one-hot current owner, or all-zero
- BUSY  out  1  state ≠ IDLE
- ABORT  out  1  one-cycle pulse when a packet is aborted

## Operation
- States: IDLE, FORWARD, TERMINATE, DISCARD. Registers: state, grant, last pointer, started flag, watchdog counter.
- run = (CURRENTSTATE == RUN_STATE).
- End marker: a transferred character with bit 8 = 1 and bits [7:0] ∈ {00, 01}.
- **IDLE**
  - If run and any SRC_VALID: grant the first valid source searching from last+1 modulo NUM_SRC.
  - Next cycle: last ← winner, started ← 0, state → FORWARD.
- **FORWARD** (owner g)
  - SRC_READY[g] = run & !TX_FULL.
  - WR_DATA = SRC_VALID[g] & SRC_READY[g] (combinational); DATA_I = SRC_DATA[g].
  - On any transfer: started ← 1.
  - On transfer of an end marker: → IDLE and GRANT clears next cycle.
  - If !run: no transfer this cycle. If started, → TERMINATE; else → DISCARD. ABORT pulses in this cycle in both cases.
- **TERMINATE**
  - Drive DATA_I = 9'h101. WR_DATA = !TX_FULL.
  - Hold until the write occurs, then → DISCARD. The write is allowed even if the link is not in Run.
- **DISCARD**
  - SRC_READY[g] = 1, WR_DATA = 0. Consumed characters are dropped.
  - On consuming an end marker → IDLE, regardless of link state.
- SRC_READY is 0 for every non-owner, and 0 for all sources in IDLE and TERMINATE.
- DATA_I = 0 whenever WR_DATA = 0.

## Timing
- Reset values: state IDLE; GRANT 0; SRC_READY 0; WR_DATA 0; DATA_I 0; BUSY 0; ABORT 0; last = NUM_SRC-1 (first grant goes to source 0); watchdog counter 0.
- Arbitration latency: request seen in cycle t → GRANT in t+1 → first transfer possible in t+1.
- Throughput: one character per cycle while owner valid, run, and !TX_FULL. TX_FULL is sampled combinationally in the same cycle.
- Minimum idle gap between packets: 1 cycle (the IDLE cycle).
- A single-character packet (EOP only) is legal.
- Simultaneous end-marker and link drop: the link drop wins (no transfer). The EEP is written, then DISCARD consumes the pending marker.
- RESET asserted mid-packet: immediate return to reset values. No EEP is injected; the source is responsible for its own reset.

## Configuration
- SPW_ARB_TIMEOUT_EN defined:
  - Counter of $clog2(TIMEOUT_CYCLES+1) bits runs in FORWARD and increments each cycle that started & !SRC_VALID[g].
  - Clears on transfer and on leaving FORWARD.
  - Reaching TIMEOUT_CYCLES → TERMINATE with an ABORT pulse.
  - Stalls caused by TX_FULL do not count.
- Undefined: no counter. FORWARD waits indefinitely for the owner.

## Test plan
- Sources 0 and 2 valid together, each with a 3-byte packet + EOP → writes in order: src0 bytes, 9'h100, then src2 bytes, 9'h100. No interleave. GRANT goes 0001 → 0000 → 0100.
- Fairness: all four sources continuously sending 1-byte + EOP packets → grant order 0,1,2,3,0; each source gets 25% of packets over 40 packets.
- TX_FULL held high for 5 cycles mid-packet → SRC_READY and WR_DATA low for those 5 cycles, no character lost, stream resumes next cycle.
- CURRENTSTATE drops from 5 to 0 after 2 bytes of a 6-byte packet → ABORT pulse; exactly one write of 9'h101; remaining 4 bytes + EOP consumed with WR_DATA = 0; BUSY falls.
- Owner stalls for TIMEOUT_CYCLES after its first byte:
  - Macro defined → EEP written, ABORT pulse.
  - Macro undefined → no write, grant held, packet completes normally when VALID returns.
- RESET asserted during FORWARD → next cycle GRANT = 0, WR_DATA = 0, and the next arbitration grants source 0 first.
